// File: rtl/ext_pkg.sv
// ============================================================================
// ext_pkg : extension-mode encodings shared by the immediate-extension stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO   = 2'b00;
  localparam ext_mode_t EXT_SIGN   = 2'b01;
  localparam ext_mode_t EXT_HIGH   = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/imm_ext_core.sv
// ============================================================================
// imm_ext_core : combinational zero/sign/upper/branch-offset immediate extender
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  ext_mode_t        mode,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_high;
  logic [OUT_W-1:0] w_branch;

  // A zero-width pad is illegal, so the equal-width case is split out.
  if (IN_W == OUT_W) begin : g_same_width
    assign w_zext = a;
    assign w_sext = a;
    assign w_high = a;
  end else begin : g_pad
    assign w_zext = {{(OUT_W-IN_W){1'b0}}, a};
    assign w_sext = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
    assign w_high = {a, {(OUT_W-IN_W){1'b0}}};
  end

  assign w_branch = w_sext << SHAMT;

  always_comb begin
    y = w_zext;
    case (mode)
      EXT_ZERO:   y = w_zext;
      EXT_SIGN:   y = w_sext;
      EXT_HIGH:   y = w_high;
      EXT_BRANCH: y = w_branch;
      default:    y = w_zext;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_ext_stage.sv
// ============================================================================
// imm_ext_stage : registered immediate-extension stage, valid/ready + skid buffer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module imm_ext_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  ext_mode_t        in_mode,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] w_ext;
  logic             w_in_xfer;
  logic             w_out_free;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .mode (in_mode),
    .a    (in_imm),
    .y    (w_ext)
  );

  // in_ready depends only on the skid flag, so out_ready never reaches it.
  assign in_ready   = !r_skid_valid;
  assign w_in_xfer  = in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ext;
        r_out_tag   <= in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ext;
      r_skid_tag   <= in_tag;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_stage.sv
// ============================================================================
// tb_imm_ext_stage : directed table + randomized scoreboard bench for imm_ext_stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_imm_ext_stage;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SHAMT = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [IN_W-1:0]  in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  imm_ext_stage #(
    .IN_W (IN_W), .OUT_W (OUT_W), .SHAMT (SHAMT), .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_imm    (in_imm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [IN_W-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [OUT_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } ent_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: arithmetic on integers, then truncated to OUT_W bits.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [1:0] m, input logic [IN_W-1:0] a);
    longint u, s;
    logic [63:0] r;
    u = longint'(a);
    s = a[IN_W-1] ? (u - (longint'(1) << IN_W)) : u;
    case (m)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = u * (longint'(1) << (OUT_W - IN_W));
      default: r = s * (longint'(1) << SHAMT);
    endcase
    return r[OUT_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] a,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    in_mode  = m;
    in_imm   = a;
    in_tag   = t;
  endtask

  vec_t vecs[6];
  ent_t q[$];

  initial begin
    vecs[0] = '{2'b01, 16'h8001, 5'd1, 32'hFFFF8001};
    vecs[1] = '{2'b00, 16'h8001, 5'd2, 32'h00008001};
    vecs[2] = '{2'b10, 16'h1234, 5'd3, 32'h12340000};
    vecs[3] = '{2'b11, 16'hFFFF, 5'd4, 32'hFFFFFFFC};
    vecs[4] = '{2'b11, 16'h7FFF, 5'd5, 32'h0001FFFC};
    vecs[5] = '{2'b01, 16'h7FFF, 5'd6, 32'h00007FFF};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_tag",   64'(out_tag),   64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed extension vectors, one transfer each with an idle cycle between.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].tag);
      tick();
      drive(1'b0, 2'b00, '0, '0);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp));
      chk($sformatf("vec%0d_tag", i),   64'(out_tag),   64'(vecs[i].tag));
      tick();
      chk($sformatf("vec%0d_drain", i), 64'(out_valid), 64'd0);
    end

    // Back-pressure: A, B fill both slots, C waits at the input.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h00A0, 5'd1);
    tick();
    drive(1'b1, 2'b00, 16'h00B0, 5'd2);
    chk("bp_ready_after_A", 64'(in_ready), 64'd1);
    tick();
    chk("bp_ready_after_B", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b00, 16'h00C0, 5'd3);
    tick();
    chk("bp_hold_data", 64'(out_data), 64'h00A0);
    chk("bp_hold_tag",  64'(out_tag),  64'd1);
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_B_valid", 64'(out_valid), 64'd1);
    chk("bp_B_data",  64'(out_data),  64'h00B0);
    chk("bp_B_tag",   64'(out_tag),   64'd2);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    chk("bp_C_valid", 64'(out_valid), 64'd1);
    chk("bp_C_data",  64'(out_data),  64'h00C0);
    chk("bp_C_tag",   64'(out_tag),   64'd3);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Streaming: every input must appear exactly one cycle later.
    begin
      logic [OUT_W-1:0] pd;
      logic [TAG_W-1:0] pt;
      logic [1:0]       m;
      logic [IN_W-1:0]  a;
      logic [TAG_W-1:0] t;
      for (int i = 0; i < 100; i++) begin
        m = 2'($urandom_range(0, 3));
        a = IN_W'($urandom);
        t = TAG_W'(i);
        drive(1'b1, m, a, t);
        chk("stream_ready", 64'(in_ready), 64'd1);
        tick();
        pd = ref_ext(m, a);
        pt = t;
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data",  64'(out_data),  64'(pd));
        chk("stream_tag",   64'(out_tag),   64'(pt));
      end
      drive(1'b0, 2'b00, '0, '0);
      tick();
    end

    // Random back-pressure with a FIFO scoreboard.
    begin
      int budget;
      ent_t e;
      logic [1:0] m;
      logic [IN_W-1:0] a;
      for (int i = 0; i < 400; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        m = 2'($urandom_range(0, 3));
        a = IN_W'($urandom);
        drive(1'($urandom_range(0, 1)), m, a, TAG_W'($urandom));
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("sb_unexpected_output", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            chk("sb_data", 64'(out_data), 64'(e.data));
            chk("sb_tag",  64'(out_tag),  64'(e.tag));
          end
        end
        if (in_valid && in_ready) q.push_back('{ref_ext(m, a), in_tag});
        tick();
      end
      drive(1'b0, 2'b00, '0, '0);
      out_ready = 1'b1;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        #1;
        if (out_valid) begin
          e = q.pop_front();
          chk("sb_drain_data", 64'(out_data), 64'(e.data));
          chk("sb_drain_tag",  64'(out_tag),  64'(e.tag));
        end
        tick();
        budget++;
      end
      chk("sb_leftover", 64'(q.size()), 64'd0);
      q.delete();
      tick();
      chk("sb_idle", 64'(out_valid), 64'd0);
    end

    // Flush with both slots full and a valid input in the flush cycle.
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 16'h1111, 5'd7);
    tick();
    drive(1'b1, 2'b01, 16'h2222, 5'd8);
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b01, 16'h3333, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset in the middle of a cycle while streaming.
    drive(1'b1, 2'b00, 16'h0AAA, 5'd10);
    tick();
    drive(1'b1, 2'b00, 16'h0BBB, 5'd11);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    tick();
    chk("arst_ignores_in", 64'(out_valid), 64'd0);
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    tick();
    chk("arst_no_spurious", 64'(out_valid), 64'd0);
    drive(1'b1, 2'b10, 16'h00CD, 5'd12);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    chk("arst_first_valid", 64'(out_valid), 64'd1);
    chk("arst_first_data",  64'(out_data),  64'h00CD0000);
    chk("arst_first_tag",   64'(out_tag),   64'd12);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised immediate-extension pipeline stage for the decode/execute boundary of the MIPS datapath.
- Extends an IN_W-bit immediate to OUT_W bits under one of four per-transfer modes:
  - zero-extend
  - sign-extend
  - upper placement (LUI)
  - sign-extend then shift left (branch offset)
- Carries a sideband tag and uses a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept under back-pressure.
- Supports a synchronous pipeline flush.

Parameters:
- IN_W, 16, immediate input width; must satisfy 1 ≤ IN_W ≤ OUT_W.
- OUT_W, 32, extended output width.
- SHAMT, 2, left-shift amount for mode EXT_BRANCH; must satisfy 0 ≤ SHAMT < OUT_W.
- TAG_W, 5, width of the sideband tag carried alongside the data (for example a destination register).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous flush; discards all held and incoming entries.
- in_valid  in  1  input transfer valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_mode  in  2  extension mode (see ext_pkg).
- in_imm  in  IN_W  immediate to extend.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_tag=0.
  - Skid entry cleared (skid_valid=0).
  - in_ready=1.
  - Inputs are ignored while rst=1.
- Extension is combinational on the input side. The extended value, not the raw immediate, is stored in the registers.
- Extension modes (a = in_imm):
  - EXT_ZERO=2'b00: {(OUT_W-IN_W) zeros, a}.
  - EXT_SIGN=2'b01: {(OUT_W-IN_W) copies of a[IN_W-1], a}.
  - EXT_HIGH=2'b10: a occupies bits [OUT_W-1:OUT_W-IN_W]; all lower bits are 0. If IN_W==OUT_W, the result is a.
  - EXT_BRANCH=2'b11: the sign-extended value shifted left by SHAMT, truncated to OUT_W bits, with zeros shifted in.
- Handshake and storage:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !skid_valid. It is a registered state, with no combinational path from out_ready.
  - Latency is 1 cycle from an accepted input to out_valid when the stage is empty or draining.
  - Throughput is 1 transfer per cycle while out_ready=1.
- Per rising edge, when flush=0:
  - Output register empty, or output transfer occurring: load it from the skid entry if skid_valid=1 (skid is cleared). Otherwise load it from the input if an input transfer occurs. Otherwise out_valid becomes 0.
  - Output register holding and stalled (out_valid=1, out_ready=0) with an input transfer: the input goes to the skid entry and skid_valid becomes 1.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data and out_tag stay stable.
- Flush:
  - flush=1 at an edge clears out_valid and skid_valid.
  - Any input transfer in that cycle is discarded.
  - in_ready=1 on the next cycle.
  - Flush has priority over every other event, including a simultaneous output transfer. That output transfer still counts as consumed by downstream.
- Reset mid-operation: all held entries are lost immediately. There are no spurious out_valid pulses after rst deasserts.
- out_data and out_tag hold their last values when out_valid=0. Their contents are don't-care and must not be checked.

Decomposition:
- Package ext_pkg contains:
  - Mode localparams EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_BRANCH.
  - The 2-bit mode type.
- One combinational sub-module, imm_ext_core:
  - Parameters IN_W, OUT_W, SHAMT.
  - Ports mode, a, y.
  - Instantiated once on the input side.
- The top level holds only the output register, the skid register and the handshake logic.

Test Plan (default parameters):
- EXT_SIGN, in_imm=16'h8001, out_ready=1 → the next cycle has out_valid=1 and out_data=32'hFFFF8001. EXT_ZERO with the same immediate → 32'h00008001.
- EXT_HIGH, in_imm=16'h1234 → out_data=32'h12340000. EXT_BRANCH with 16'hFFFF → 32'hFFFFFFFC. EXT_BRANCH with 16'h7FFF → 32'h0001FFFC.
- Back-pressure, in order:
  - Hold out_ready=0 and send A (tag 1) then B (tag 2). in_ready becomes 0 the cycle after B is accepted.
  - Present C and hold it at the input.
  - Raise out_ready. The output sequence is A, B, C with tags 1, 2, 3, with no gaps once draining.
- Streaming: 100 back-to-back random transfers with out_ready=1 → 100 outputs in order, each exactly 1 cycle after its input, matching a reference model.
- Flush with both entries full and in_valid=1 → the next cycle has out_valid=0 and in_ready=1. The flushed entries and the input from the flush cycle never appear at the output.
- Assert rst asynchronously mid-stream (between edges) → out_valid=0 immediately. After rst deasserts, the first output is the first input accepted after reset.
